// File: rtl/inject_burst_gen_pkg.sv
// ============================================================================
// inject_burst_gen_pkg
// Shared FSM state encoding and default field widths for inject_burst_gen.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inject_burst_gen_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int N_W_DEF   = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/inject_burst_gen_trig_sync_edge.sv
// ============================================================================
// trig_sync_edge
// Two-flop synchroniser plus registered rising-edge detector for a slow input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_pulse;

  // The pulse is registered, so it appears one cycle after sync2 first goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pulse <= r_sync2 & ~r_sync3;
    end
  end

  assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/inject_burst_gen.sv
// ============================================================================
// inject_burst_gen
// Fires one programmable burst of injection pulses per synchronised trigger.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inject_burst_gen
  import inject_burst_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int N_W   = N_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [N_W-1:0]   cfg_count,
  input  logic             clr_missed,
  output logic             inj_out,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   pulses_sent,
  output logic             missed_trig
);

  logic             w_start;
  logic [CNT_W-1:0] w_w_eff;
  logic [CNT_W-1:0] w_w_m1;
  logic [CNT_W-1:0] w_low_m1;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_start_idle;
  logic             w_enter_high;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_w_m1;
  logic [CNT_W-1:0] r_low_m1;
  logic [N_W-1:0]   r_n;
  logic [N_W-1:0]   r_pulses;
  logic             r_missed;
  logic             r_inj;
  logic             r_busy;
  logic             r_done;

  trig_sync_edge u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (trig_in),
    .pulse (w_start)
  );

  // Low phase is kept as a length (not a period) so W at full scale cannot overflow W+1.
  assign w_w_eff  = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
  assign w_w_m1   = w_w_eff - CNT_W'(1);
  assign w_low_m1 = (cfg_period <= w_w_eff) ? '0 : (cfg_period - w_w_eff - CNT_W'(1));

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (cfg_count == '0) begin
            w_next = ST_DONE;
          end else if (cfg_delay == '0) begin
            w_next     = ST_HIGH;
            w_cnt_next = w_w_m1;
          end else begin
            w_next     = ST_DELAY;
            w_cnt_next = cfg_delay - CNT_W'(1);
          end
        end
      end
      ST_DELAY: begin
        if (r_cnt == '0) begin
          w_next     = ST_HIGH;
          w_cnt_next = r_w_m1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (r_cnt == '0) begin
          if (r_pulses < r_n) begin
            w_next     = ST_LOW;
            w_cnt_next = r_low_m1;
          end else begin
            w_next = ST_DONE;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (r_cnt == '0) begin
          w_next     = ST_HIGH;
          w_cnt_next = r_w_m1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_start_idle = w_start && (r_state == ST_IDLE);
  assign w_enter_high = (w_next == ST_HIGH) && (r_state != ST_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_w_m1   <= '0;
      r_low_m1 <= '0;
      r_n      <= '0;
      r_pulses <= '0;
      r_missed <= 1'b0;
      r_inj    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_inj   <= (w_next == ST_HIGH);
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);

      if (w_start_idle) begin
        r_w_m1   <= w_w_m1;
        r_low_m1 <= w_low_m1;
        r_n      <= cfg_count;
        r_pulses <= w_enter_high ? N_W'(1) : '0;
      end else if (w_enter_high) begin
        r_pulses <= r_pulses + N_W'(1);
      end

      // A retrigger in the same cycle as a clear must leave the flag set.
      if (w_start && (r_state != ST_IDLE)) begin
        r_missed <= 1'b1;
      end else if (clr_missed) begin
        r_missed <= 1'b0;
      end
    end
  end

  assign inj_out     = r_inj;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_sent = r_pulses;
  assign missed_trig = r_missed;

endmodule

`default_nettype wire

// File: tb/tb_inject_burst_gen.sv
// ============================================================================
// tb_inject_burst_gen
// Self-checking bench for inject_burst_gen using an expected-trace queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inject_burst_gen;

  localparam int CNT_W = 16;
  localparam int N_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             trig_in;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_period;
  logic [N_W-1:0]   cfg_count;
  logic             clr_missed;
  logic             inj_out;
  logic             busy;
  logic             done;
  logic [N_W-1:0]   pulses_sent;
  logic             missed_trig;

  int checks   = 0;
  int failures = 0;

  // Each entry is {inj_out, busy, done} expected after one clock edge.
  logic [2:0] sb[$];

  inject_burst_gen #(.CNT_W(CNT_W), .N_W(N_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig_in     (trig_in),
    .cfg_delay   (cfg_delay),
    .cfg_width   (cfg_width),
    .cfg_period  (cfg_period),
    .cfg_count   (cfg_count),
    .clr_missed  (clr_missed),
    .inj_out     (inj_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent),
    .missed_trig (missed_trig)
  );

  always #5 clk = ~clk;

  // Expected outputs after edge k, where edge 0 is the first edge sampling trig_in=1.
  function automatic logic [2:0] model(int k, int d, int w, int p, int n);
    int we, pe, t0, tend;
    logic ei, eb, ed;
    we = (w == 0) ? 1 : w;
    pe = (p <= we) ? we + 1 : p;
    t0 = 3 + d;
    ei = 1'b0;
    eb = 1'b0;
    ed = 1'b0;
    if (n == 0) begin
      eb = (k == 3);
      ed = (k == 3);
    end else begin
      tend = t0 + (n - 1) * pe + we;
      ed = (k == tend);
      eb = (k >= 3) && (k <= tend);
      ei = (k >= t0) && (k < tend) && (((k - t0) % pe) < we);
    end
    return {ei, eb, ed};
  endfunction

  task automatic push_burst(int len, int d, int w, int p, int n);
    for (int k = 0; k < len; k++) sb.push_back(model(k, d, w, p, n));
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_burst(int d, int w, int p, int n);
    @(negedge clk);
    cfg_delay  = CNT_W'(d);
    cfg_width  = CNT_W'(w);
    cfg_period = CNT_W'(p);
    cfg_count  = N_W'(n);
    trig_in    = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({inj_out, busy, done, pulses_sent, missed_trig} !== '0) begin
      failures++;
      $display("FAIL reset_during got=%b/%b/%b/%0d/%b required=0/0/0/0/0",
               inj_out, busy, done, pulses_sent, missed_trig);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({inj_out, busy, done, pulses_sent, missed_trig} !== '0) begin
      failures++;
      $display("FAIL reset_after got=%b/%b/%b/%0d/%b required=0/0/0/0/0",
               inj_out, busy, done, pulses_sent, missed_trig);
    end
  endtask

  task automatic test_basic();
    logic [2:0] e_v;
    start_burst(0, 2, 5, 3);
    push_burst(262, 0, 2, 5, 3);
    for (int k = 0; k < 262; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL basic_trace k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 5) begin
        checks++;
        if (pulses_sent !== 8'd1) begin
          failures++;
          $display("FAIL basic_pulses_mid got=%0d required=1", pulses_sent);
        end
      end
      if (k == 249) trig_in = 1'b0;
    end
    checks++;
    if (pulses_sent !== 8'd3) begin
      failures++;
      $display("FAIL basic_pulses got=%0d required=3", pulses_sent);
    end
  endtask

  task automatic test_degenerate();
    logic [2:0] e_v;
    start_burst(0, 0, 0, 2);
    push_burst(10, 0, 0, 0, 2);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL degenerate_trace k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 2) trig_in = 1'b0;
    end
    checks++;
    if (pulses_sent !== 8'd2) begin
      failures++;
      $display("FAIL degenerate_pulses got=%0d required=2", pulses_sent);
    end
  endtask

  task automatic test_delay();
    logic [2:0] e_v;
    start_burst(10, 1, 0, 1);
    push_burst(20, 10, 1, 0, 1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL delay_trace k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 2) trig_in = 1'b0;
    end
  endtask

  task automatic test_zero_count();
    logic [2:0] e_v;
    start_burst(5, 3, 6, 0);
    push_burst(10, 5, 3, 6, 0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL zero_count_trace k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 2) trig_in = 1'b0;
    end
    checks++;
    if (pulses_sent !== 8'd0) begin
      failures++;
      $display("FAIL zero_count_pulses got=%0d required=0", pulses_sent);
    end
  endtask

  task automatic test_retrigger();
    logic [2:0] e_v;
    start_burst(0, 2, 100, 4);
    push_burst(320, 0, 2, 100, 4);
    for (int k = 0; k < 320; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL retrig_trace k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 40 || k == 62 || k == 312) begin
        checks++;
        if (missed_trig !== 1'b0) begin
          failures++;
          $display("FAIL retrig_missed_clear k=%0d got=%b required=0", k, missed_trig);
        end
      end
      if (k == 60 || k == 105) begin
        checks++;
        if (missed_trig !== 1'b1) begin
          failures++;
          $display("FAIL retrig_missed_set k=%0d got=%b required=1", k, missed_trig);
        end
      end
      case (k)
        2:   trig_in = 1'b0;
        49:  trig_in = 1'b1;
        53:  trig_in = 1'b0;
        60:  clr_missed = 1'b1;
        61:  clr_missed = 1'b0;
        99:  trig_in = 1'b1;
        102: clr_missed = 1'b1;
        103: begin clr_missed = 1'b0; trig_in = 1'b0; end
        310: clr_missed = 1'b1;
        311: clr_missed = 1'b0;
        default: ;
      endcase
    end
    checks++;
    if (pulses_sent !== 8'd4) begin
      failures++;
      $display("FAIL retrig_pulses got=%0d required=4", pulses_sent);
    end
  endtask

  task automatic test_cfg_change();
    logic [2:0] e_v;
    start_burst(0, 2, 10, 3);
    push_burst(30, 0, 2, 10, 3);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL cfg_change_trace k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 2) trig_in = 1'b0;
      if (k == 7) cfg_width = CNT_W'(50);
    end
  endtask

  task automatic test_max_count();
    logic [2:0] e_v;
    start_burst(0, 1, 2, 255);
    push_burst(520, 0, 1, 2, 255);
    for (int k = 0; k < 520; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL max_count_trace k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 2) trig_in = 1'b0;
    end
    checks++;
    if (pulses_sent !== 8'd255) begin
      failures++;
      $display("FAIL max_count_pulses got=%0d required=255", pulses_sent);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] e_v;
    start_burst(0, 4, 10, 3);
    push_burst(5, 0, 4, 10, 3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL areset_pre k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 2) trig_in = 1'b0;
    end
    // Assert reset mid-cycle while inj_out is high; outputs must drop before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({inj_out, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL areset_immediate got=%b required=000", {inj_out, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({inj_out, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL areset_quiet k=%0d got=%b required=000", k, {inj_out, busy, done});
      end
    end
    start_burst(1, 1, 3, 2);
    push_burst(12, 1, 1, 3, 2);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      e_v = sb.pop_front();
      checks++;
      if ({inj_out, busy, done} !== e_v) begin
        failures++;
        $display("FAIL areset_post k=%0d got=%b required=%b", k, {inj_out, busy, done}, e_v);
      end
      if (k == 2) trig_in = 1'b0;
    end
    checks++;
    if (pulses_sent !== 8'd2) begin
      failures++;
      $display("FAIL areset_post_pulses got=%0d required=2", pulses_sent);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    trig_in    = 1'b0;
    cfg_delay  = '0;
    cfg_width  = '0;
    cfg_period = '0;
    cfg_count  = '0;
    clr_missed = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    idle(5);
    test_basic();
    idle(5);
    test_degenerate();
    idle(5);
    test_delay();
    idle(5);
    test_zero_count();
    idle(5);
    test_retrigger();
    idle(5);
    test_cfg_change();
    idle(5);
    test_max_count();
    idle(5);
    test_async_reset();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
